// File: rtl/jtbubl_snd_comm.sv
// Sound-CPU side of the main<->sound command channel: command latch with pending flag and NMI,
// reply latch with a timed strobe, and a synchronised, stretched sound-CPU reset.
module jtbubl_snd_comm #(
  parameter int STB_W = 4,
  parameter int RST_W = 16
) (
  input  logic       clk24,
  input  logic       rst,
  input  logic [7:0] snd_latch,
  input  logic       snd_stb,
  input  logic       main_flag,
  input  logic       snd_rstn,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [7:0] main_latch,
  output logic       main_stb,
  output logic       snd_flag,
  output logic       snd_nmi_n,
  output logic       snd_cpu_rstn
);

  typedef enum logic [1:0] {HOLD, STRETCH, RUN} st_t;

  st_t        r_st, w_st_nxt;
  logic       r_rsn_s1, r_rsn_s2;
  logic [7:0] r_rcnt;
  logic       w_run;

  logic       r_stb_l, r_wr_l, r_rd_l, r_rd_a0;
  logic       r_flag, r_nmi_en, r_nmi_n;
  logic [7:0] r_dout, r_main_latch, w_rd_mux;
  logic [3:0] r_scnt;
  logic       w_wr, w_rd, w_wr_ev, w_rd_end, w_stb_rise;

  // Reset FSM: state register, stretch counter and synchroniser
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      r_st     <= HOLD;
      r_rsn_s1 <= 1'b0;
      r_rsn_s2 <= 1'b0;
      r_rcnt   <= 8'd0;
    end else begin
      r_rsn_s1 <= snd_rstn;
      r_rsn_s2 <= r_rsn_s1;
      r_st     <= w_st_nxt;
      if (r_st == HOLD && r_rsn_s2)  r_rcnt <= 8'(RST_W);
      else if (r_st == STRETCH)      r_rcnt <= r_rcnt - 8'd1;
    end
  end

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      HOLD:    if (r_rsn_s2) w_st_nxt = STRETCH;
      STRETCH: if (!r_rsn_s2) w_st_nxt = HOLD;
               else if (r_rcnt == 8'd1) w_st_nxt = RUN;
      RUN:     if (!r_rsn_s2) w_st_nxt = HOLD;
      default: w_st_nxt = HOLD;
    endcase
  end

  always_comb begin
    w_run        = (r_st == RUN);
    snd_cpu_rstn = w_run;
  end

  // CPU strobes are ignored outside RUN so a held-in-reset Z80 cannot touch state
  assign w_wr       = cs & ~wr_n & w_run;
  assign w_rd       = cs & ~rd_n & w_run;
  assign w_wr_ev    = w_wr & ~r_wr_l;
  assign w_rd_end   = ~w_rd & r_rd_l & w_run;
  assign w_stb_rise = snd_stb & ~r_stb_l;

  always_comb begin
    case (addr)
      2'd0:    w_rd_mux = snd_latch;
      2'd1:    w_rd_mux = {6'h3F, main_flag, r_flag};
      default: w_rd_mux = 8'hFF;
    endcase
  end

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      r_stb_l      <= 1'b0;
      r_wr_l       <= 1'b0;
      r_rd_l       <= 1'b0;
      r_rd_a0      <= 1'b0;
      r_flag       <= 1'b0;
      r_nmi_en     <= 1'b0;
      r_nmi_n      <= 1'b1;
      r_dout       <= 8'hFF;
      r_main_latch <= 8'h00;
      r_scnt       <= 4'd0;
    end else begin
      r_stb_l <= snd_stb;
      r_wr_l  <= w_wr;
      r_rd_l  <= w_rd;
      if (w_rd) r_rd_a0 <= (addr == 2'd0);
      r_dout  <= w_rd ? w_rd_mux : 8'hFF;
      // set has priority so a command arriving during the ack is never lost
      if (w_stb_rise)
        r_flag <= 1'b1;
      else if ((w_rd_end && r_rd_a0) || (w_wr_ev && addr == 2'd3))
        r_flag <= 1'b0;
      if (!w_run)                          r_nmi_en <= 1'b0;
      else if (w_wr_ev && addr == 2'd1)    r_nmi_en <= 1'b1;
      else if (w_wr_ev && addr == 2'd2)    r_nmi_en <= 1'b0;
      r_nmi_n <= ~(r_nmi_en & r_flag);
      if (w_wr_ev && addr == 2'd0) begin
        r_main_latch <= din;
        r_scnt       <= 4'(STB_W);
      end else if (!w_run)
        r_scnt <= 4'd0;
      else if (r_scnt != 4'd0)
        r_scnt <= r_scnt - 4'd1;
    end
  end

  assign dout       = r_dout;
  assign main_latch = r_main_latch;
  assign main_stb   = w_run && (r_scnt != 4'd0);
  assign snd_flag   = r_flag;
  assign snd_nmi_n  = r_nmi_n;

endmodule

// File: tb/tb_jtbubl_snd_comm.sv
// Directed bench for jtbubl_snd_comm: reset release, command/NMI, reply strobe, status, HOLD retention.
module tb_jtbubl_snd_comm;
  logic       clk24 = 1'b0, rst = 1'b1;
  logic [7:0] snd_latch = 8'h00, din = 8'h00;
  logic       snd_stb = 1'b0, main_flag = 1'b0, snd_rstn = 1'b0;
  logic       cs = 1'b0, rd_n = 1'b1, wr_n = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [7:0] dout, main_latch;
  logic       main_stb, snd_flag, snd_nmi_n, snd_cpu_rstn;

  int n_chk = 0, n_pass = 0;
  int stb_hi, stb_rise;
  logic stb_prev;

  jtbubl_snd_comm #(.STB_W(4), .RST_W(16)) dut (
    .clk24(clk24), .rst(rst), .snd_latch(snd_latch), .snd_stb(snd_stb),
    .main_flag(main_flag), .snd_rstn(snd_rstn), .cs(cs), .addr(addr),
    .rd_n(rd_n), .wr_n(wr_n), .din(din), .dout(dout), .main_latch(main_latch),
    .main_stb(main_stb), .snd_flag(snd_flag), .snd_nmi_n(snd_nmi_n),
    .snd_cpu_rstn(snd_cpu_rstn)
  );

  always #5 clk24 = ~clk24;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk24); #1; end
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; addr = a; din = d; wr_n = 1'b0;
    tick();
    cs = 1'b0; wr_n = 1'b1;
    tick();
  endtask

  initial begin
    tick(2);
    chk("rst_dout",  dout, 8'hFF);
    chk("rst_mlat",  main_latch, 8'h00);
    chk("rst_mstb",  main_stb, 1'b0);
    chk("rst_flag",  snd_flag, 1'b0);
    chk("rst_nmi",   snd_nmi_n, 1'b1);
    chk("rst_cpurn", snd_cpu_rstn, 1'b0);
    rst = 1'b0;
    tick(2);

    // release: 2 sync + 16 stretch cycles low, then high
    snd_rstn = 1'b1;
    tick(18);
    chk("rel_low",  snd_cpu_rstn, 1'b0);
    tick();
    chk("rel_high", snd_cpu_rstn, 1'b1);

    // command with NMI enabled, then read it back
    cpu_wr(2'd1, 8'h00);
    snd_latch = 8'h5A; snd_stb = 1'b1;
    tick();
    chk("cmd_flag", snd_flag, 1'b1);
    snd_stb = 1'b0;
    tick();
    chk("cmd_nmi", snd_nmi_n, 1'b0);
    cs = 1'b1; addr = 2'd0; rd_n = 1'b0;
    tick();
    chk("rd0_dout", dout, 8'h5A);
    tick();
    chk("rd0_flag_mid", snd_flag, 1'b1);
    cs = 1'b0; rd_n = 1'b1;
    tick();
    chk("rd0_flag_end", snd_flag, 1'b0);
    chk("rd0_dout_end", dout, 8'hFF);
    tick();
    chk("rd0_nmi_end", snd_nmi_n, 1'b1);

    // new command on the same edge as the read end: set wins
    snd_stb = 1'b1; tick();
    snd_stb = 1'b0; tick();
    chk("race_pre_nmi", snd_nmi_n, 1'b0);
    cs = 1'b1; addr = 2'd0; rd_n = 1'b0;
    tick(2);
    cs = 1'b0; rd_n = 1'b1; snd_stb = 1'b1;
    tick();
    chk("race_flag", snd_flag, 1'b1);
    snd_stb = 1'b0;
    tick();
    chk("race_nmi", snd_nmi_n, 1'b0);

    // ack without read
    cs = 1'b1; addr = 2'd3; wr_n = 1'b0;
    tick();
    chk("ack_flag", snd_flag, 1'b0);
    chk("ack_dout", dout, 8'hFF);
    cs = 1'b0; wr_n = 1'b1;
    tick();
    chk("ack_nmi", snd_nmi_n, 1'b1);

    // 10-cycle reply write: one pulse of exactly 4 cycles
    stb_hi = 0; stb_rise = 0; stb_prev = main_stb;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin cs = 1'b1; addr = 2'd0; din = 8'h3C; wr_n = 1'b0; end
      if (i == 10) begin cs = 1'b0; wr_n = 1'b1; end
      tick();
      if (main_stb) stb_hi++;
      if (main_stb && !stb_prev) stb_rise++;
      stb_prev = main_stb;
    end
    chk("rep_latch", main_latch, 8'h3C);
    chk("rep_stb_len", stb_hi, 4);
    chk("rep_stb_cnt", stb_rise, 1);

    // status read
    main_flag = 1'b1;
    cs = 1'b1; addr = 2'd1; rd_n = 1'b0;
    tick();
    chk("stat_dout", dout, 8'hFE);
    cs = 1'b0; rd_n = 1'b1;
    tick();
    chk("stat_dout_end", dout, 8'hFF);

    // back to HOLD; command queued there survives the release
    snd_rstn = 1'b0;
    tick(3);
    chk("hold_cpurn", snd_cpu_rstn, 1'b0);
    cs = 1'b1; addr = 2'd0; rd_n = 1'b0;
    tick();
    chk("hold_cs_ign", dout, 8'hFF);
    cs = 1'b0; rd_n = 1'b1;
    snd_latch = 8'h11; snd_stb = 1'b1; tick();
    snd_stb = 1'b0; tick();
    chk("hold_flag", snd_flag, 1'b1);
    chk("hold_nmi", snd_nmi_n, 1'b1);
    chk("hold_mlat", main_latch, 8'h3C);
    snd_rstn = 1'b1;
    tick(19);
    chk("hold_rel", snd_cpu_rstn, 1'b1);
    chk("hold_flag_kept", snd_flag, 1'b1);
    chk("hold_nmi_noen", snd_nmi_n, 1'b1);
    cpu_wr(2'd1, 8'h00);
    chk("hold_nmi_en", snd_nmi_n, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
